// File: rtl/pe_seq.sv
// pe_seq: systolic-array PE that owns its weight sequencing.
// Local weight file, start/count FSM, stationary or rotating weights.
module pe_seq #(
   parameter int ACT_BITWIDTH      = 8,
   parameter int WGT_BITWIDTH      = 8,
   parameter int SUM_IN_BITWIDTH   = 32,
   parameter int SUM_OUT_BITWIDTH  = SUM_IN_BITWIDTH,
   parameter int MEM_ADDR_BITWIDTH = 4,
   parameter int CNT_BITWIDTH      = 8,
   parameter     TRUNCATION_MODE   = "MSB"
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         w_wr_en,
   input  logic [MEM_ADDR_BITWIDTH-1:0] w_wr_addr,
   input  logic [WGT_BITWIDTH-1:0]      w_wr_data,
   input  logic                         cfg_mode,
   input  logic [MEM_ADDR_BITWIDTH-1:0] cfg_base,
   input  logic [MEM_ADDR_BITWIDTH-1:0] cfg_len,
   input  logic [CNT_BITWIDTH-1:0]      cfg_count,
   input  logic                         seq_start,
   input  logic [ACT_BITWIDTH-1:0]      act_in,
   input  logic                         act_valid_in,
   input  logic [SUM_IN_BITWIDTH-1:0]   sum_in,
   output logic [ACT_BITWIDTH-1:0]      act_out,
   output logic                         act_valid_out,
   output logic [SUM_OUT_BITWIDTH-1:0]  sum_out,
   output logic                         out_valid,
   output logic                         busy,
   output logic                         done
);

   localparam int DEPTH = 2 ** MEM_ADDR_BITWIDTH;
   localparam int IW    = SUM_IN_BITWIDTH + 1;
   localparam int SO    = SUM_OUT_BITWIDTH;

   localparam logic signed [IW-1:0] SAT_MAX =
      {{(IW-SO+1){1'b0}}, {(SO-1){1'b1}}};
   localparam logic signed [IW-1:0] SAT_MIN =
      {{(IW-SO+1){1'b1}}, {(SO-1){1'b0}}};

   localparam logic [CNT_BITWIDTH-1:0] CNT_ONE =
      {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};
   localparam logic [MEM_ADDR_BITWIDTH-1:0] PTR_ONE =
      {{(MEM_ADDR_BITWIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, RUN} state_t;

   state_t state;
   state_t state_nxt;

   logic [WGT_BITWIDTH-1:0]      mem [DEPTH];
   logic                         mode_q;
   logic [MEM_ADDR_BITWIDTH-1:0] base_q;
   logic [MEM_ADDR_BITWIDTH-1:0] len_q;
   logic [CNT_BITWIDTH-1:0]      count_q;
   logic [MEM_ADDR_BITWIDTH-1:0] ptr;
   logic [CNT_BITWIDTH-1:0]      beat_cnt;
   logic [WGT_BITWIDTH-1:0]      hold_w;

   logic                         beat;
   logic                         last;
   logic [WGT_BITWIDTH-1:0]      w_sel;
   logic [MEM_ADDR_BITWIDTH-1:0] ptr_end;
   logic signed [IW-1:0]         a_ext;
   logic signed [IW-1:0]         w_ext;
   logic signed [IW-1:0]         s_ext;
   logic signed [IW-1:0]         inter;
   logic [SO-1:0]                sum_fmt;

   // weight file: synchronous write, never reset
   always_ff @(posedge clk) begin
      if (w_wr_en) mem[w_wr_addr] <= w_wr_data;
   end

   // beat qualification and next-state selection
   always_comb begin
      state_nxt = state;
      beat      = (state == RUN) && act_valid_in && !seq_start;
      last      = beat && (beat_cnt == count_q);
      if (seq_start) state_nxt = RUN;
      else if (last) state_nxt = IDLE;
   end

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   assign busy    = (state == RUN);
   assign ptr_end = base_q + len_q;
   assign w_sel   = mode_q ? mem[ptr] : hold_w;

   // widened signed MAC; the extra bit keeps it overflow free
   always_comb begin
      a_ext = {{(IW-ACT_BITWIDTH){act_in[ACT_BITWIDTH-1]}}, act_in};
      w_ext = {{(IW-WGT_BITWIDTH){w_sel[WGT_BITWIDTH-1]}}, w_sel};
      s_ext = {sum_in[SUM_IN_BITWIDTH-1], sum_in};
      inter = s_ext + a_ext * w_ext;
   end

   generate
      if (TRUNCATION_MODE == "SAT") begin : g_sat
         // clamp to the signed output range
         always_comb begin
            if (inter > SAT_MAX)      sum_fmt = SAT_MAX[SO-1:0];
            else if (inter < SAT_MIN) sum_fmt = SAT_MIN[SO-1:0];
            else                      sum_fmt = inter[SO-1:0];
         end
      end else begin : g_msb
         // keep the top bits: arithmetic right shift
         always_comb begin
            sum_fmt = SO'(inter >>> (IW - SO));
         end
      end
   endgenerate

   // sequence bookkeeping: cfg latch, pointer, beat counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q   <= 1'b0;
         base_q   <= '0;
         len_q    <= '0;
         count_q  <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
         hold_w   <= '0;
      end else if (seq_start) begin
         mode_q   <= cfg_mode;
         base_q   <= cfg_base;
         len_q    <= cfg_len;
         count_q  <= cfg_count;
         ptr      <= cfg_base;
         beat_cnt <= '0;
         hold_w   <= mem[cfg_base];
      end else if (beat) begin
         beat_cnt <= beat_cnt + CNT_ONE;
         if (mode_q) begin
            if (ptr == ptr_end) ptr <= base_q;
            else                ptr <= ptr + PTR_ONE;
         end
      end
   end

   // registered result, activation forwarding and done pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         act_out       <= '0;
         act_valid_out <= 1'b0;
         sum_out       <= '0;
         out_valid     <= 1'b0;
         done          <= 1'b0;
      end else begin
         act_out       <= act_in;
         act_valid_out <= act_valid_in;
         out_valid     <= beat;
         done          <= last;
         if (beat) sum_out <= sum_fmt;
      end
   end

endmodule
